// File: rtl/adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding, operation
// select values and the bit-counter sizing helper.
package adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bit counter must hold 0..WIDTH-1, but never collapse below one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell used as the serial adder's bit slice.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice, LSB first, one bit per
// clock, with a start/busy/done handshake and held result registers.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sh_shift;

    full_adder u_slice (
        .A    (ra_q[0]),
        .B    (rb_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_c)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is at the LSB.
    generate
        if (WIDTH == 1) begin : g_sh_w1
            assign sh_shift = fa_s;
        end else begin : g_sh_wn
            assign sh_shift = {fa_s, sh_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        sh_d    = sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = (sub == OP_ADD) ? b : ~b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                ra_d    = ra_q >> 1;
                rb_d    = rb_q >> 1;
                sh_d    = sh_shift;
                carry_d = fa_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // carry_q here is the carry into the MSB slice
                    sum_d   = sh_shift;
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            sh_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            sh_q    <= sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1: a driver pushes
// arithmetic-model expectations, a negedge monitor pops them on each done.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start8, sub8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       start1, sub1, busy1, done1, cout1, ovf1;
    logic [0:0] a1, b1, sum1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         due;
    } exp_t;

    exp_t       q8[$];
    exp_t       q1[$];
    logic [7:0] hold_sum [2];
    logic       hold_cout[2];
    logic       hold_ovf [2];
    int         run_len  [2];
    int         cyc      = 0;
    int         n_vec    = 0;
    int         n_bad    = 0;
    bit         mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input int w, input longint ua, input longint ub,
                                   input logic s, input int due);
        exp_t   e;
        longint full = longint'(1) << w;
        longint half = longint'(1) << (w - 1);
        longint sa   = (ua >= half) ? ua - full : ua;
        longint sb   = (ub >= half) ? ub - full : ub;
        longint r    = s ? ua - ub : ua + ub;
        longint sr   = s ? sa - sb : sa + sb;
        e.sum  = 8'(r & (full - 1));
        e.cout = s ? (ua >= ub) : (r >= full);
        e.ovf  = (sr < -half) || (sr >= half);
        e.due  = due;
        return e;
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? q8.size() : q1.size();
    endfunction

    task automatic mon(input int k, input logic dn, input logic bz,
                       input logic [7:0] s, input logic c, input logic o);
        exp_t e;
        int   w = (k == 0) ? 8 : 1;
        if (dn) begin
            check($sformatf("busy_len%0d", w), run_len[k], w);
            check($sformatf("busy_in_done%0d", w), bz, 0);
            run_len[k] = 0;
            if (qsize(k) == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done%0d: done=1 with no pending op (cycle %0d)", w, cyc);
            end else begin
                e = (k == 0) ? q8.pop_front() : q1.pop_front();
                check($sformatf("sum%0d", w), s, e.sum);
                check($sformatf("cout%0d", w), c, e.cout);
                check($sformatf("ovf%0d", w), o, e.ovf);
                check($sformatf("latency%0d", w), cyc, e.due);
                hold_sum[k]  = e.sum;
                hold_cout[k] = e.cout;
                hold_ovf[k]  = e.ovf;
            end
        end else begin
            if (bz) run_len[k]++;
            else    run_len[k] = 0;
            check($sformatf("hold_sum%0d", w), s, hold_sum[k]);
            check($sformatf("hold_cout%0d", w), c, hold_cout[k]);
            check($sformatf("hold_ovf%0d", w), o, hold_ovf[k]);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, done8, busy8, sum8, cout8, ovf8);
            mon(1, done1, busy1, {7'b0, sum1}, cout1, ovf1);
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic op(input int k, input longint ua_in, input longint ub_in,
                      input logic s, input bit hold);
        int     w  = (k == 0) ? 8 : 1;
        longint ua = ua_in & ((longint'(1) << w) - 1);
        longint ub = ub_in & ((longint'(1) << w) - 1);
        int     t  = 0;
        while ((k == 0) ? busy8 : busy1) begin
            @(negedge clk);
            t++;
            if (t > 100) begin
                n_vec++;
                n_bad++;
                $display("FAIL busy_timeout%0d: busy never dropped", w);
                return;
            end
        end
        if (k == 0) begin
            start8 = 1'b1; a8 = 8'(ua); b8 = 8'(ub); sub8 = s;
            q8.push_back(model(w, ua, ub, s, cyc + 1 + w));
        end else begin
            start1 = 1'b1; a1 = 1'(ua); b1 = 1'(ub); sub1 = s;
            q1.push_back(model(w, ua, ub, s, cyc + 1 + w));
        end
        @(negedge clk);
        if (k == 0) begin
            start8 = hold; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        end else begin
            start1 = hold; a1 = 1'($urandom); b1 = 1'($urandom); sub1 = 1'($urandom);
        end
    endtask

    task automatic drain(input int k);
        int t = 0;
        while (qsize(k) != 0 || ((k == 0) ? busy8 : busy1)) begin
            @(negedge clk);
            t++;
            if (t > 200) begin
                n_vec++;
                n_bad++;
                $display("FAIL drain_timeout%0d: %0d results never appeared", k == 0 ? 8 : 1, qsize(k));
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        start8 = 1'b0;
        start1 = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q8.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            hold_sum[k] = '0; hold_cout[k] = 1'b0; hold_ovf[k] = 1'b0; run_len[k] = 0;
        end
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_sum8", sum8, 0);
        check("rst_cout8", cout8, 0);
        check("rst_ovf8", ovf8, 0);
        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        check("rst_sum1", sum1, 0);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
        @(negedge clk);
        do_reset();
        mon_en = 1'b1;

        // Directed WIDTH=8 cases
        op(0, 100, 27, 1'b0, 1'b0);     drain(0);
        op(0, 200, 100, 1'b0, 1'b0);    drain(0);
        op(0, 100, 50, 1'b0, 1'b0);     drain(0);
        op(0, 5, 7, 1'b1, 1'b0);        drain(0);
        op(0, 8'h80, 1, 1'b1, 1'b0);    drain(0);

        // Start pulsed mid-RUN with other operands must be ignored
        op(0, 33, 44, 1'b0, 1'b0);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd250; b8 = 8'd250; sub8 = 1'b1;
        repeat (3) @(negedge clk);
        start8 = 1'b0;
        drain(0);

        // Back-to-back: start held high through RUN and DONE
        op(0, 17, 240, 1'b1, 1'b1);
        op(0, 127, 1, 1'b0, 1'b1);
        op(0, 9, 9, 1'b1, 1'b0);
        drain(0);

        // Reset in the fourth RUN cycle: abort, no done afterwards
        op(0, 55, 66, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        do_reset();
        repeat (20) @(negedge clk);

        // Random WIDTH=8 traffic
        for (int i = 0; i < 40; i++) begin
            op(0, $urandom_range(0, 255), $urandom_range(0, 255),
               1'($urandom), (i != 39) && ($urandom_range(0, 3) == 0));
        end
        drain(0);

        // WIDTH=1 full truth table, then random back-to-back
        for (int i = 0; i < 8; i++) begin
            op(1, (i >> 2) & 1, (i >> 1) & 1, 1'(i & 1), 1'b0);
            drain(1);
        end
        for (int i = 0; i < 20; i++) begin
            op(1, $urandom_range(0, 1), $urandom_range(0, 1), 1'($urandom), i != 19);
        end
        drain(1);

        check("leftover8", q8.size(), 0);
        check("leftover1", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
